// File: rtl/mole_round_ctrl_if.sv
// mole_round_ctrl_if
//   Bundles the game-control and display signals of the whack-a-mole round
//   sequencer. The master side (edge detectors / game front end) drives the
//   pulses and the pop-up duration; the slave side (mole_round_ctrl) drives
//   the registered display outputs.
//
//   Signal protocol: there is no valid/ready flow control on this bus. Every
//   input is a single-cycle pulse qualified only by clk (start_i, tick_i,
//   each bit of hit_i) and is acted on in the cycle it is high, so a pulse
//   that arrives when the sequencer cannot use it is dropped, never stalled.
//   up_time_i is a level, sampled only when a mole pops up. done_o is a
//   1-cycle pulse; all other outputs are levels.
//
//   Ports (from the slave view):
//     start_i    in   game start pulse
//     tick_i     in   time-base enable
//     hit_i      in   per-button press pulses
//     up_time_i  in   pop-up duration in ticks
//     mole_o     out  one-hot lit mole, zero when dark
//     score_o    out  correct hits, saturating
//     miss_o     out  timeouts plus wrong presses, saturating
//     busy_o     out  game in progress
//     done_o     out  end-of-game pulse
interface mole_round_ctrl_if #(
  parameter int N_MOLES = 8
);
  logic               start_i;
  logic               tick_i;
  logic [N_MOLES-1:0] hit_i;
  logic [7:0]         up_time_i;
  logic [N_MOLES-1:0] mole_o;
  logic [7:0]         score_o;
  logic [7:0]         miss_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    output start_i, tick_i, hit_i, up_time_i,
    input  mole_o, score_o, miss_o, busy_o, done_o
  );

  modport slave (
    input  start_i, tick_i, hit_i, up_time_i,
    output mole_o, score_o, miss_o, busy_o, done_o
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl
//   Round sequencer for the whack-a-mole game. Lights one mole at a time
//   from an 8-bit Galois LFSR, times each pop-up in tick_i pulses and scores
//   the button pulses against the lit mole. All outputs are registered.
//
//   Ports:
//     clk          clock
//     rst_n        asynchronous active-low reset
//     bus          mole_round_ctrl_if.slave (start/tick/hit/up_time in,
//                  mole/score/miss/busy/done out)
//     dbg_state_o  current FSM state (0 IDLE, 1 GAP, 2 UP, 3 DONE)
//
//   Optional feature macro: MOLE_SPEEDUP_EN. When defined, every correct hit
//   shortens later pop-ups in the same game by one tick (floor of 1 tick).
module mole_round_ctrl #(
  parameter int         N_MOLES   = 8,
  parameter int         N_ROUNDS  = 16,
  parameter int         GAP_TICKS = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mole_round_ctrl_if.slave        bus,
  output logic [1:0]              dbg_state_o
);
  localparam int IW = $clog2(N_MOLES);
  localparam int GW = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GAP = 2'd1, S_UP = 2'd2, S_DONE = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [7:0]         round_q, round_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [7:0]         up_q, up_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         score_q, score_d;
  logic [7:0]         miss_q, miss_d;
  logic [N_MOLES-1:0] mole_q, mole_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Event decode for the current cycle.
  logic [N_MOLES-1:0] lit_mask;
  logic [IW-1:0]      idx_raw, idx_pick;
  logic [7:0]         round_inc, up_eff;
  logic               hit_ok, hit_bad, timeout, pop_end, last_round, gap_end;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign lit_mask   = N_MOLES'(1) << idx_q;
  // A correct press wins over wrong bits and over a coincident final tick.
  assign hit_ok     = (state_q == S_UP) && |(bus.hit_i & lit_mask);
  assign hit_bad    = (state_q == S_UP) && !hit_ok && |(bus.hit_i & ~lit_mask);
  assign timeout    = (state_q == S_UP) && !hit_ok && bus.tick_i && (up_q == 8'd1);
  assign pop_end    = hit_ok || timeout;
  assign round_inc  = round_q + 8'd1;
  assign last_round = (round_inc == 8'(N_ROUNDS));
  // The gap ends on the tick that takes the counter to zero.
  assign gap_end    = (state_q == S_GAP) && bus.tick_i && (gap_q == GW'(1));

  // IW-bit wrap of idx_raw + 1 is exactly "mod N_MOLES" for a power of two.
  assign idx_raw  = lfsr_q[IW-1:0];
  assign idx_pick = (idx_raw == idx_q) ? idx_raw + IW'(1) : idx_raw;

`ifdef MOLE_SPEEDUP_EN
  logic [7:0] offset_q, offset_d;
  assign up_eff = (bus.up_time_i > offset_q) ? bus.up_time_i - offset_q : 8'd1;
`else
  assign up_eff = (bus.up_time_i == 8'd0) ? 8'd1 : bus.up_time_i;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      round_q <= 8'd0;
      gap_q   <= '0;
      up_q    <= 8'd0;
      idx_q   <= '0;
      score_q <= 8'd0;
      miss_q  <= 8'd0;
      mole_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      round_q <= round_d;
      gap_q   <= gap_d;
      up_q    <= up_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      mole_q  <= mole_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MOLE_SPEEDUP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) offset_q <= 8'd0;
    else        offset_q <= offset_d;
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = S_UP;
      S_UP:    if (pop_end) state_d = last_round ? S_DONE : S_GAP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic. Outputs are computed from state_d so the
  // registered values line up with the state they describe.
  always_comb begin
    // LFSR free-runs in every state: x^8+x^6+x^5+x^4+1, right-shifting form.
    lfsr_d  = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    round_d = round_q;
    gap_d   = gap_q;
    up_d    = up_q;
    idx_d   = idx_q;
    score_d = score_q;
    miss_d  = miss_q;
`ifdef MOLE_SPEEDUP_EN
    offset_d = offset_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          score_d = 8'd0;
          miss_d  = 8'd0;
          round_d = 8'd0;
          gap_d   = GW'(GAP_TICKS);
`ifdef MOLE_SPEEDUP_EN
          offset_d = 8'd0;
`endif
        end
      end
      S_GAP: begin
        if (bus.tick_i) gap_d = gap_q - GW'(1);
        if (gap_end) begin
          idx_d = idx_pick;
          up_d  = up_eff;
        end
      end
      S_UP: begin
        if (bus.tick_i && !pop_end) up_d = up_q - 8'd1;
        if (hit_ok) begin
          score_d = sat_add(score_q, 2'd1);
`ifdef MOLE_SPEEDUP_EN
          offset_d = sat_add(offset_q, 2'd1);
`endif
        end
        // A wrong press and a timeout can land in the same cycle.
        miss_d = sat_add(miss_q, {1'b0, hit_bad} + {1'b0, timeout});
        if (pop_end) begin
          round_d = round_inc;
          gap_d   = GW'(GAP_TICKS);
        end
      end
      default: ;
    endcase
    mole_d = (state_d == S_UP) ? (N_MOLES'(1) << idx_d) : '0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign bus.mole_o   = mole_q;
  assign bus.score_o  = score_q;
  assign bus.miss_o   = miss_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl
//   Bench for mole_round_ctrl with N_MOLES=8, N_ROUNDS=4, GAP_TICKS=2.
//   Drives games through the interface, pushes expected pop-up durations and
//   end-of-game {score, miss} into queues, and a negedge monitor pops and
//   compares them as the DUT produces them.
module tb_mole_round_ctrl;
  localparam int N    = 8;
  localparam int NR   = 4;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int off_m = 0;

  logic [15:0] exp_q[$];
  logic [31:0] dur_q[$];

  mole_round_ctrl_if #(.N_MOLES(N)) bus ();

  mole_round_ctrl #(
    .N_MOLES(N), .N_ROUNDS(NR), .GAP_TICKS(GAP), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // Expected pop-up length for the current speedup offset.
  function automatic int exp_up(input int up, input int off);
`ifdef MOLE_SPEEDUP_EN
    return (up > off) ? up - off : 1;
`else
    return (up == 0) ? 1 : up;
`endif
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    logic [15:0] w;
    w = {v, v} << s;
    return w[15:8];
  endfunction

  // Driver tasks (called at posedge+1)
  task automatic cyc(input logic t, input logic [N-1:0] h);
    bus.tick_i = t;
    bus.hit_i  = h;
    @(posedge clk); #1;
    bus.tick_i = 1'b0;
    bus.hit_i  = '0;
  endtask

  task automatic start_game(input logic [7:0] up);
    bus.up_time_i = up;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    off_m = 0;
    check("busy_rise", bus.busy_o, 1);
    check("score_clr", bus.score_o, 0);
    check("miss_clr", bus.miss_o, 0);
  endtask

  task automatic wait_mole(output logic [N-1:0] lit);
    int n;
    n = 0;
    while (bus.mole_o == '0 && n < 100) begin
      cyc(1'b1, '0);
      n++;
    end
    check("gap_ticks", n, GAP);
    lit = bus.mole_o;
  endtask

  task automatic pop_timeout(input int dur);
    dur_q.push_back(dur);
    repeat (dur) cyc(1'b1, '0);
    check("mole_off_timeout", bus.mole_o, 0);
  endtask

  task automatic pop_hit_last(input int dur, input logic [N-1:0] lit);
    dur_q.push_back(dur);
    repeat (dur - 1) cyc(1'b1, '0);
    cyc(1'b1, lit);
    check("mole_off_hit", bus.mole_o, 0);
    off_m++;
  endtask

  task automatic pop_quick(input logic [N-1:0] lit);
    dur_q.push_back(0);
    cyc(1'b0, '0);
    cyc(1'b0, lit);
    check("mole_off_quick", bus.mole_o, 0);
    off_m++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy_o && n < 20) begin
      cyc(1'b0, '0);
      n++;
    end
    check("idle_reached", bus.busy_o, 0);
  endtask

  // Monitor / scoreboard
  logic [N-1:0] lit_prev, last_mole;
  logic         done_prev;
  int           tick_cnt;

  always @(negedge clk) begin
    logic [15:0] e;
    logic [31:0] d;
    if (!rst_n) begin
      lit_prev  = '0;
      last_mole = '0;
      done_prev = 1'b0;
      tick_cnt  = 0;
    end else begin
      if (done_prev) begin
        check("done_width", bus.done_o, 0);
        check("busy_fall", bus.busy_o, 0);
      end
      if (bus.done_o) begin
        check("busy_at_done", bus.busy_o, 1);
        check("mole_at_done", bus.mole_o, 0);
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("result_score_miss", {bus.score_o, bus.miss_o}, e);
        end
      end
      done_prev = bus.done_o;
      if (!bus.busy_o) last_mole = '0;
      if (bus.mole_o != '0 && lit_prev == '0) begin
        check("mole_onehot", $onehot(bus.mole_o), 1);
        check("mole_repeat", bus.mole_o == last_mole, 0);
        last_mole = bus.mole_o;
        tick_cnt  = 0;
      end
      if (bus.mole_o == '0 && lit_prev != '0 && dur_q.size() > 0) begin
        d = dur_q.pop_front();
        check("up_duration", tick_cnt, d);
      end
      if (bus.mole_o != '0 && bus.tick_i) tick_cnt++;
      lit_prev = bus.mole_o;
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] lit, wr;
    bus.start_i   = 1'b0;
    bus.tick_i    = 1'b0;
    bus.hit_i     = '0;
    bus.up_time_i = 8'd5;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.mole_o, bus.score_o, bus.miss_o, bus.busy_o, bus.done_o}, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-UP, then idle pulses with no start.
    start_game(8'd5);
    wait_mole(lit);
    pop_quick(lit);
    check("score_before_reset", bus.score_o, 1);
    wait_mole(lit);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.mole_o, bus.score_o, bus.miss_o, bus.busy_o, bus.done_o}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin
      cyc(1'($urandom_range(0, 1)), N'($urandom_range(0, 255)));
      check("idle_outputs", {bus.mole_o, bus.score_o, bus.miss_o, bus.busy_o, bus.done_o}, 0);
    end

    // Full correct game.
    start_game(8'd5);
    exp_q.push_back({8'd4, 8'd0});
    repeat (NR) begin
      wait_mole(lit);
      pop_quick(lit);
    end
    wait_idle();

    // All timeouts.
    start_game(8'd5);
    exp_q.push_back({8'd0, 8'd4});
    repeat (NR) begin
      wait_mole(lit);
      pop_timeout(exp_up(5, off_m));
    end
    wait_idle();

    // Wrong presses, coincident events, start while busy.
    start_game(8'd5);
    exp_q.push_back({8'd3, 8'd3});
    wait_mole(lit);
    wr = rotl(lit, $urandom_range(1, N - 1));
    cyc(1'b0, wr);
    check("mole_stays_1", bus.mole_o, lit);
    cyc(1'b0, ~lit);
    check("mole_stays_2", bus.mole_o, lit);
    check("miss_two_wrong", bus.miss_o, 2);
    pop_timeout(exp_up(5, off_m));
    check("miss_after_timeout", bus.miss_o, 3);
    wait_mole(lit);
    pop_hit_last(exp_up(5, off_m), lit);
    check("hit_on_final_tick_score", bus.score_o, 1);
    check("hit_on_final_tick_miss", bus.miss_o, 3);
    bus.start_i = 1'b1;
    cyc(1'b0, '0);
    bus.start_i = 1'b0;
    check("start_ignored_busy", bus.busy_o, 1);
    check("start_ignored_score", bus.score_o, 1);
    wait_mole(lit);
    dur_q.push_back(0);
    cyc(1'b0, '1);
    off_m++;
    check("both_bits_score", bus.score_o, 2);
    check("both_bits_miss", bus.miss_o, 3);
    wait_mole(lit);
    pop_hit_last(exp_up(5, off_m), lit);
    wait_idle();

    // Speedup game: hit every mole on its final tick.
    start_game(8'd3);
    exp_q.push_back({8'd4, 8'd0});
    repeat (NR) begin
      wait_mole(lit);
      pop_hit_last(exp_up(3, off_m), lit);
    end
    wait_idle();

    // Selection over 256 rounds with up_time 0.
    for (int g = 0; g < 64; g++) begin
      repeat ($urandom_range(0, 5)) cyc(1'b0, '0);
      start_game(8'd0);
      exp_q.push_back({8'd0, 8'd4});
      repeat (NR) begin
        wait_mole(lit);
        pop_timeout(exp_up(0, off_m));
      end
      wait_idle();
    end

    repeat (3) cyc(1'b0, '0);
    check("exp_q_drained", exp_q.size(), 0);
    check("dur_q_drained", dur_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
